// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared types and constants for the bit-serial adder controller.
//   state_t                  : controller FSM state, 2-bit encoding
//   SERIAL_ADD_WIDTH_DEFAULT : default operand/result width
// ---------------------------------------------------------------------------
package serial_add_pkg;

    localparam int SERIAL_ADD_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/result bundle between a requester (master) and serial_add_ctrl
// (slave).
//   start     : request; accepted only while the controller is idle
//   a, b, cin : operands, sampled on the accepted start cycle
//   sub       : subtract select (only when SERIAL_ADD_SUB_EN is defined)
//   busy      : high while bits are being processed
//   done      : one-cycle pulse, sum/cout valid in the same cycle
//   sum, cout : result, held until the next accepted start
//
// Handshake: start is a level sampled at each rising edge. It is acted upon
// only when the controller is idle; while busy or finishing it is ignored
// and nothing is queued. Each accepted start produces exactly one done pulse
// unless reset intervenes.
//
// Build option: SERIAL_ADD_SUB_EN adds the sub signal.
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::SERIAL_ADD_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
// Purely combinational 1-bit full adder; the single arithmetic cell that the
// serial controller time-shares across all bit positions.
//   a, b, cin : input bits
//   sum, cout : sum bit and carry-out
// ---------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial WIDTH-bit adder controller. Computes {cout,sum} = a + b + cin
// one bit per clock, LSB first, through a single fa_cell.
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset, priority over start
//   bus       : serial_add_ctrl_if slave (start/a/b/cin[/sub] in,
//               busy/done/sum/cout out)
//   dbg_state : current FSM state
//
// Timing: start accepted at edge N -> busy for WIDTH cycles -> one DONE
// cycle -> done pulse (with sum/cout) in the cycle after edge N+WIDTH+1.
//
// Build option: SERIAL_ADD_SUB_EN enables bus.sub (a - b via ~b + 1).
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    bus,
    output state_t              dbg_state
);

    localparam int            CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_sr_next;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result bits arrive LSB first, so they enter at the MSB and drift down;
    // after WIDTH shifts the register holds the full result in place.
    always_comb begin
        sum_sr_next            = sum_sr >> 1;
        sum_sr_next[WIDTH-1]   = fa_sum;
    end

    // Subtraction is two's complement: a + ~b + 1, cin is not used.
    always_comb begin
        b_load     = bus.b;
        carry_load = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
        if (bus.sub) begin
            b_load     = ~bus.b;
            carry_load = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= b_load;
                        carry  <= carry_load;
                        sum_sr <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_sr_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here.
                    sum_q  <= sum_sr;
                    cout_q <= carry;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl: one 8-bit instance for the main
// scenarios and one 2-bit instance swept over every operand combination.
// Cycle index j counts negedge samples after the accepting edge N
// (j = 0 is the cycle after edge N); done is expected at j = WIDTH+1.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(2)) bus2 ();
    state_t st8;
    state_t st2;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8), .dbg_state(st8));
    serial_add_ctrl #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2), .dbg_state(st2));

    int n_cmp = 0;
    int n_bad = 0;

    // observations of the last op8/op2 run
    int         r_done_cnt, r_done_j, r_busy_cnt;
    logic [7:0] r_sum, r_sum_hold, r_sum_at;
    logic       r_cout, r_busy_at, r_cout_at;
    state_t     r_st_at;

    // ---------------- driver tasks ----------------
    // One accepted start on the 8-bit DUT; optionally injects a second start
    // pulse (zero operands) at cycle start_j and a reset at cycle rst_j.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input int start_j, input int rst_j);
        @(posedge clk); #1;
        bus8.a = av; bus8.b = bv; bus8.cin = cv; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        r_done_cnt = 0; r_done_j = -1; r_busy_cnt = 0;
        r_sum = '0; r_cout = 1'b0; r_sum_hold = '0;
        r_busy_at = 1'bx; r_sum_at = 'x; r_cout_at = 1'bx; r_st_at = DONE;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (bus8.busy === 1'b1) r_busy_cnt++;
            if (bus8.done === 1'b1) begin
                r_done_cnt++;
                if (r_done_j < 0) begin
                    r_done_j = j; r_sum = bus8.sum; r_cout = bus8.cout;
                end
            end
            if (rst_j >= 0 && j == rst_j + 1) begin
                r_busy_at = bus8.busy; r_sum_at = bus8.sum;
                r_cout_at = bus8.cout; r_st_at = st8;
            end
            r_sum_hold = bus8.sum;
            if (j == start_j) begin
                bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'h00;
            end else begin
                bus8.start = 1'b0;
            end
            rst = (j == rst_j);
        end
    endtask

    task automatic op2(input logic [1:0] av, input logic [1:0] bv, input logic cv);
        @(posedge clk); #1;
        bus2.a = av; bus2.b = bv; bus2.cin = cv; bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        r_done_cnt = 0; r_done_j = -1; r_sum = '0; r_cout = 1'b0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (bus2.done === 1'b1) begin
                r_done_cnt++;
                if (r_done_j < 0) begin
                    r_done_j = j; r_sum = {6'd0, bus2.sum}; r_cout = bus2.cout;
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy8: got %b want 0", bus8.busy); end
        n_cmp++; if (bus8.done !== 1'b0) begin n_bad++; $display("FAIL reset_done8: got %b want 0", bus8.done); end
        n_cmp++; if (bus8.sum !== 8'h00) begin n_bad++; $display("FAIL reset_sum8: got %h want 00", bus8.sum); end
        n_cmp++; if (bus8.cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout8: got %b want 0", bus8.cout); end
        n_cmp++; if (st8 !== IDLE) begin n_bad++; $display("FAIL reset_state8: got %0d want 0", st8); end
        n_cmp++; if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus2.sum !== 2'b00)
            begin n_bad++; $display("FAIL reset_dut2: got busy %b done %b sum %b want 0 0 00", bus2.busy, bus2.done, bus2.sum); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        op8(8'h5A, 8'h3C, 1'b0, -1, -1);
        n_cmp++; if (r_busy_cnt !== 8) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 8", r_busy_cnt); end
        n_cmp++; if (r_done_j !== 9) begin n_bad++; $display("FAIL basic_latency: got %0d want 9", r_done_j); end
        n_cmp++; if (r_done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", r_done_cnt); end
        n_cmp++; if (r_sum !== 8'h96) begin n_bad++; $display("FAIL basic_sum: got %h want 96", r_sum); end
        n_cmp++; if (r_cout !== 1'b0) begin n_bad++; $display("FAIL basic_cout: got %b want 0", r_cout); end
        n_cmp++; if (r_sum_hold !== 8'h96) begin n_bad++; $display("FAIL basic_sum_held: got %h want 96", r_sum_hold); end
    endtask

    task automatic test_carry();
        op8(8'hFF, 8'h01, 1'b0, -1, -1);
        n_cmp++; if (r_sum !== 8'h00) begin n_bad++; $display("FAIL carry1_sum: got %h want 00", r_sum); end
        n_cmp++; if (r_cout !== 1'b1) begin n_bad++; $display("FAIL carry1_cout: got %b want 1", r_cout); end
        op8(8'hFF, 8'hFF, 1'b1, -1, -1);
        n_cmp++; if (r_sum !== 8'hFF) begin n_bad++; $display("FAIL carry2_sum: got %h want ff", r_sum); end
        n_cmp++; if (r_cout !== 1'b1) begin n_bad++; $display("FAIL carry2_cout: got %b want 1", r_cout); end
        n_cmp++; if (r_done_j !== 9) begin n_bad++; $display("FAIL carry2_latency: got %0d want 9", r_done_j); end
    endtask

    task automatic test_exhaustive_w2();
        logic [2:0] want;
        for (int i = 0; i < 32; i++) begin
            op2(i[4:3], i[2:1], i[0]);
            want = {1'b0, i[4:3]} + {1'b0, i[2:1]} + {2'b00, i[0]};
            n_cmp++; if ({r_cout, r_sum[1:0]} !== want)
                begin n_bad++; $display("FAIL w2_result a=%0d b=%0d c=%0d: got %0d want %0d", i[4:3], i[2:1], i[0], {r_cout, r_sum[1:0]}, want); end
            n_cmp++; if (r_done_cnt !== 1 || r_done_j !== 3)
                begin n_bad++; $display("FAIL w2_done a=%0d b=%0d c=%0d: got count %0d at %0d want 1 at 3", i[4:3], i[2:1], i[0], r_done_cnt, r_done_j); end
        end
    endtask

    task automatic test_ignore_start();
        // second start in the middle of RUN
        op8(8'h12, 8'h34, 1'b0, 3, -1);
        n_cmp++; if (r_sum !== 8'h46) begin n_bad++; $display("FAIL ign_run_sum: got %h want 46", r_sum); end
        n_cmp++; if (r_cout !== 1'b0) begin n_bad++; $display("FAIL ign_run_cout: got %b want 0", r_cout); end
        n_cmp++; if (r_done_cnt !== 1) begin n_bad++; $display("FAIL ign_run_done_count: got %0d want 1", r_done_cnt); end
        n_cmp++; if (r_busy_cnt !== 8) begin n_bad++; $display("FAIL ign_run_busy: got %0d want 8", r_busy_cnt); end
        // second start during the DONE cycle
        op8(8'h21, 8'h43, 1'b0, 8, -1);
        n_cmp++; if (r_sum !== 8'h64) begin n_bad++; $display("FAIL ign_done_sum: got %h want 64", r_sum); end
        n_cmp++; if (r_done_cnt !== 1) begin n_bad++; $display("FAIL ign_done_done_count: got %0d want 1", r_done_cnt); end
        n_cmp++; if (r_busy_cnt !== 8) begin n_bad++; $display("FAIL ign_done_busy: got %0d want 8", r_busy_cnt); end
    endtask

    task automatic test_reset_mid();
        op8(8'h77, 8'h11, 1'b0, -1, 3);
        n_cmp++; if (r_busy_at !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", r_busy_at); end
        n_cmp++; if (r_sum_at !== 8'h00) begin n_bad++; $display("FAIL rstmid_sum: got %h want 00", r_sum_at); end
        n_cmp++; if (r_cout_at !== 1'b0) begin n_bad++; $display("FAIL rstmid_cout: got %b want 0", r_cout_at); end
        n_cmp++; if (r_st_at !== IDLE) begin n_bad++; $display("FAIL rstmid_state: got %0d want 0", r_st_at); end
        n_cmp++; if (r_done_cnt !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", r_done_cnt); end
        n_cmp++; if (r_busy_cnt !== 4) begin n_bad++; $display("FAIL rstmid_busy_cycles: got %0d want 4", r_busy_cnt); end
        op8(8'h01, 8'h01, 1'b0, -1, -1);
        n_cmp++; if (r_sum !== 8'h02 || r_cout !== 1'b0) begin n_bad++; $display("FAIL rstmid_after: got %b/%h want 0/02", r_cout, r_sum); end
    endtask

    task automatic test_back_to_back();
        int d1_j, d2_j, dcnt;
        logic [7:0] s1, s2;
        d1_j = -1; d2_j = -1; dcnt = 0; s1 = '0; s2 = '0;
        @(posedge clk); #1;
        bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 23; j++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) begin
                dcnt++;
                if (d1_j < 0) begin d1_j = j; s1 = bus8.sum; end
                else if (d2_j < 0) begin d2_j = j; s2 = bus8.sum; end
            end
            if (j == 9) begin bus8.a = 8'h10; bus8.b = 8'h20; end
            if (j == 10) bus8.start = 1'b0;
        end
        bus8.start = 1'b0;
        n_cmp++; if (d1_j !== 9 || s1 !== 8'h03) begin n_bad++; $display("FAIL b2b_first: got j=%0d sum=%h want j=9 sum=03", d1_j, s1); end
        n_cmp++; if (d2_j !== 19) begin n_bad++; $display("FAIL b2b_interval: got j=%0d want 19", d2_j); end
        n_cmp++; if (s2 !== 8'h30) begin n_bad++; $display("FAIL b2b_second_sum: got %h want 30", s2); end
        n_cmp++; if (dcnt !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", dcnt); end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        bus8.sub = 1'b1;
        op8(8'h10, 8'h01, 1'b0, -1, -1);
        n_cmp++; if (r_sum !== 8'h0F || r_cout !== 1'b1) begin n_bad++; $display("FAIL sub1: got %b/%h want 1/0f", r_cout, r_sum); end
        op8(8'h01, 8'h02, 1'b0, -1, -1);
        n_cmp++; if (r_sum !== 8'hFF || r_cout !== 1'b0) begin n_bad++; $display("FAIL sub2: got %b/%h want 0/ff", r_cout, r_sum); end
        bus8.sub = 1'b0;
        op8(8'h10, 8'h01, 1'b1, -1, -1);
        n_cmp++; if (r_sum !== 8'h12 || r_cout !== 1'b0) begin n_bad++; $display("FAIL sub_off_add: got %b/%h want 0/12", r_cout, r_sum); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus8.sub = 1'b0; bus2.sub = 1'b0;
`endif
        test_reset();
        test_basic();
        test_carry();
        test_exhaustive_w2();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
